// File: rtl/alu2_div_pkg.sv
// Shared definitions for the cpu2 sequential divider: flag-word bit
// positions (C/V/Z/S layout shared with the ALU) and divider state encodings.
package alu2_div_pkg;

  localparam int CIDX = 0;
  localparam int VIDX = 1;
  localparam int ZIDX = 2;
  localparam int SIDX = 3;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/alu2_div_adder.sv
// Plain ripple adder with carry in/out; the divider uses it as a subtractor
// by feeding the inverted divisor with carry-in set.
module alu2_div_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
);

  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_i};

endmodule

// File: rtl/alu2_div.sv
// Sequential restoring divider for the cpu2 execute stage: one quotient bit
// per cycle on magnitudes, sign fix-up and flag-word update at the end.
module alu2_div
  import alu2_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] di,
  input  logic [WIDTH-1:0] bi,
  input  logic [WIDTH-1:0] fi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic [WIDTH-1:0] fo,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] racc_q, racc_d;
  logic [WIDTH-1:0] fi_q, fi_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] fo_q, fo_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] partial, trial, quo_fix, rem_fix;
  logic             no_borrow;

  // dvd_q doubles as the quotient shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  assign partial = {racc_q[WIDTH-2:0], dvd_q[WIDTH-1]};

  alu2_div_adder #(.WIDTH(WIDTH)) u_sub (
    .a_i   (partial),
    .b_i   (~dvs_q),
    .c_i   (1'b1),
    .sum_o (trial),
    .c_o   (no_borrow)
  );

  assign quo_fix = zero_q ? '1 : (qneg_q ? -dvd_q : dvd_q);
  assign rem_fix = zero_q ? dvd_q : (rneg_q ? -racc_q : racc_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    racc_d  = racc_q;
    fi_d    = fi_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    fo_d    = fo_q;
    div0_d  = div0_q;

    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (start) begin
          // A zero divisor keeps the raw dividend so it can be returned as rem.
          zero_d  = (bi == '0);
          dvd_d   = (sgn && di[WIDTH-1] && bi != '0) ? -di : di;
          dvs_d   = (sgn && bi[WIDTH-1]) ? -bi : bi;
          racc_d  = '0;
          cnt_d   = '0;
          qneg_d  = sgn & (di[WIDTH-1] ^ bi[WIDTH-1]);
          rneg_d  = sgn & di[WIDTH-1];
          ovf_d   = sgn && (di == MIN_VAL) && (bi == '1);
          fi_d    = fi;
          state_d = (bi == '0) ? DIV_FIX : DIV_RUN;
        end else if (state_q == DIV_DONE) begin
          state_d = DIV_IDLE;
        end
      end
      DIV_RUN: begin
        racc_d = no_borrow ? trial : partial;
        dvd_d  = {dvd_q[WIDTH-2:0], no_borrow};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        quo_d        = quo_fix;
        rem_d        = rem_fix;
        div0_d       = zero_q;
        fo_d         = fi_q;
        fo_d[ZIDX]   = (quo_fix == '0);
        fo_d[SIDX]   = quo_fix[WIDTH-1];
        fo_d[CIDX]   = (rem_fix != '0);
        fo_d[VIDX]   = zero_q | ovf_q;
        state_d      = DIV_DONE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      racc_q  <= '0;
      fi_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      fo_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      racc_q  <= racc_d;
      fi_q    <= fi_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      fo_q    <= fo_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = (state_q == DIV_RUN) || (state_q == DIV_FIX);
  assign done = (state_q == DIV_DONE);
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign fo   = fo_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_alu2_div.sv
// Self-checking bench for alu2_div: fixed vector table, randomized operations
// against an arithmetic reference model, and hand-written timing sequences.
module tb_alu2_div;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_n, start, sgn;
  logic [W-1:0]  di, bi, fi;
  logic          busy, done, div0;
  logic [W-1:0]  quo, rem, fo;

  int checks = 0;
  int failures = 0;

  alu2_div #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .sgn     (sgn),
    .di      (di),
    .bi      (bi),
    .fi      (fi),
    .busy    (busy),
    .done    (done),
    .quo     (quo),
    .rem     (rem),
    .fo      (fo),
    .div0    (div0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] f;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [W-1:0] fo;
    logic         z;
  } vec_t;

  vec_t tbl[11];

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] f);
    sgn   = s;
    di    = a;
    bi    = b;
    fi    = f;
    start = 1'b1;
  endtask

  // Called #1 after a rising edge; returns the cycle count until done is seen.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Truncating division on plain integers; flag word built from its results.
  task automatic refModel(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] f, output logic [W-1:0] q,
                          output logic [W-1:0] r, output logic [W-1:0] fe, output logic z);
    longint sa, sb, sq, sr;
    logic ov;
    ov = 1'b0;
    z  = (b == 0);
    if (z) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q  = 32'h8000_0000;
      r  = 0;
      ov = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0];
      r  = sr[31:0];
    end
    fe    = f;
    fe[0] = (r != 0);
    fe[1] = z | ov;
    fe[2] = (q == 0);
    fe[3] = q[31];
  endtask

  task automatic checkOp(input string name, input vec_t v);
    int lat;
    applyStimulus(v.s, v.a, v.b, v.f);
    waitDone(lat);
    checkOutput({name, " latency"}, 32'(lat), v.z ? 32'd2 : 32'd34);
    checkOutput({name, " quo"}, quo, v.q);
    checkOutput({name, " rem"}, rem, v.r);
    checkOutput({name, " fo"}, fo, v.fo);
    checkOutput({name, " div0"}, 32'(div0), 32'(v.z));
    checkOutput({name, " busy@done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   lat;
    int   sawDone;
    logic [W-1:0] a, b;

    tbl[0]  = '{1'b0, 32'd100,       32'd7,         32'h0,         32'd14,        32'd2,         32'h1,         1'b0};
    tbl[1]  = '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'h0,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'h9,         1'b0};
    tbl[2]  = '{1'b0, 32'd0,         32'd5,         32'h0,         32'd0,         32'd0,         32'h4,         1'b0};
    tbl[3]  = '{1'b0, 32'd5,         32'd0,         32'hABCD_1200, 32'hFFFF_FFFF, 32'd5,         32'hABCD_120B, 1'b1};
    tbl[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 32'd0,         32'hA,         1'b0};
    tbl[5]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'd0,         32'h8000_0000, 32'h5,         1'b0};
    tbl[6]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hF,         32'hFFFF_FFFD, 32'd1,         32'h9,         1'b0};
    tbl[7]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFF0, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    tbl[8]  = '{1'b1, 32'hFFFF_FFFB, 32'd0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hB,         1'b1};
    tbl[9]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, 32'd0,         32'h8,         1'b0};
    tbl[10] = '{1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0,         32'd1,         32'h7FFF_FFFE, 32'h1,         1'b0};

    reset_n = 1'b0;
    start   = 1'b0;
    sgn     = 1'b0;
    di      = '0;
    bi      = '0;
    fi      = '0;
    #3;
    checkOutput("reset quo", quo, 32'd0);
    checkOutput("reset rem", rem, 32'd0);
    checkOutput("reset fo", fo, 32'd0);
    checkOutput("reset flags", {28'd0, busy, done, div0, 1'b0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) checkOp($sformatf("vec%0d", i), tbl[i]);

    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      v.s = 1'($urandom_range(0, 1));
      v.a = a;
      v.b = b;
      v.f = $urandom;
      refModel(v.s, v.a, v.b, v.f, v.q, v.r, v.fo, v.z);
      checkOp($sformatf("rand%0d", n), v);
    end

    // start pulsed mid-RUN must be ignored and not queued
    applyStimulus(1'b0, 32'd1000, 32'd7, 32'h0);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      start = (i == 10);
      if (i == 10) begin
        di = 32'd5;
        bi = 32'd1;
      end
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    checkOutput("midrun latency", 32'(lat), 32'd34);
    checkOutput("midrun quo", quo, 32'd142);
    checkOutput("midrun rem", rem, 32'd6);
    @(posedge clk);
    #1;
    checkOutput("midrun no requeue", {30'd0, busy, done}, 32'd0);

    // back-to-back: start presented in the DONE cycle
    applyStimulus(1'b0, 32'd200, 32'd9, 32'h0);
    waitDone(lat);
    checkOutput("b2b first quo", quo, 32'd22);
    checkOutput("b2b first rem", rem, 32'd2);
    v.s = 1'b1;
    v.a = 32'hFFFF_FFCE;
    v.b = 32'd7;
    v.f = 32'h0000_5500;
    refModel(v.s, v.a, v.b, v.f, v.q, v.r, v.fo, v.z);
    applyStimulus(v.s, v.a, v.b, v.f);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b busy", 32'(busy), 32'd1);
    waitDone(lat);
    checkOutput("b2b latency", 32'(lat + 1), 32'd34);
    checkOutput("b2b quo", quo, v.q);
    checkOutput("b2b rem", rem, v.r);
    checkOutput("b2b fo", fo, v.fo);

    // asynchronous reset at cycle 10 of RUN aborts with no done pulse
    applyStimulus(1'b0, 32'd77777, 32'd13, 32'h0);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abort quo", quo, 32'd0);
    checkOutput("abort rem", rem, 32'd0);
    checkOutput("abort fo", fo, 32'd0);
    checkOutput("abort flags", {28'd0, busy, done, div0, 1'b0}, 32'd0);
    sawDone = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) sawDone++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) sawDone++;
    end
    checkOutput("abort no done", 32'(sawDone), 32'd0);

    v.s = 1'b0;
    v.a = 32'd12345;
    v.b = 32'd11;
    v.f = 32'h0;
    refModel(v.s, v.a, v.b, v.f, v.q, v.r, v.fo, v.z);
    checkOp("after reset", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu2_div.md
# alu2_div

Sequential 32-bit integer divider beside the combinational ALU in the cpu2 execute stage. The ALU does single-cycle multiply; this block does the inverse operation. It takes Rd (dividend) and Rb (divisor) plus the current flag word on a start handshake. It returns quotient, remainder and an updated flag word in the same C/V/Z/S layout after a fixed multi-cycle latency, while the pipeline stalls on `busy`.

## Interface
- `WIDTH`, 32, operand/result/flag word width.
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  reset: one clock; reset is asynchronous and active-low.
- `start`  input  1  request; sampled only when `busy`=0.
- `sgn`  input  1  1 = signed (two's complement), 0 = unsigned; sampled with `start`.
- `di`  input  WIDTH  dividend (Rd content).
- `bi`  input  WIDTH  divisor (Rb content).
- `fi`  input  WIDTH  input flag word, sampled with `start`.
- `busy`  output  1  operation in progress.
- `done`  output  1  one-cycle pulse; results valid.
- `quo`  output  WIDTH  quotient, held until next accepted start.
- `rem`  output  WIDTH  remainder, held likewise.
- `fo`  output  WIDTH  output flag word, held likewise.
- `div0`  output  1  last operation had divisor 0, held likewise.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: one quotient bit per cycle, counter 0..WIDTH-1.
  - FIX: sign correction and result/flag registration.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Accept: `start`=1 with state IDLE or DONE. On the accepting edge:
  - latch |di|, |bi| (absolute values when `sgn`=1, raw otherwise);
  - latch the result signs: quotient sign = di[MSB]^bi[MSB], remainder sign = di[MSB] (only when `sgn`);
  - latch `fi`;
  - go to RUN with counter 0.
- `start` while in RUN/FIX is ignored and not queued.
- Divide by zero (`bi`=0 at accept): skip RUN and go straight to FIX. Result: quo = all-ones, rem = di unmodified, `div0`=1.
- RUN step (restoring):
  - partial = {rem_acc[WIDTH-2:0], dvd[MSB]};
  - trial = partial − divisor;
  - if no borrow, rem_acc = trial and the quotient bit is 1; else rem_acc = partial and the bit is 0;
  - shift the dividend left.
  - After the step with counter=WIDTH-1, go to FIX.
- FIX: negate quo/rem as latched (truncating division; remainder takes the dividend's sign), register outputs, go to DONE.
- Signed overflow (MIN / −1): quo = MIN (0x80000000), rem = 0, V=1.
- Flags: `fo` = latched `fi` with these bits replaced, all other bits passed through unchanged:
  - Z = (quo==0);
  - S = quo[MSB];
  - C = (rem!=0);
  - V = div0 | signed overflow.
- Reset: state IDLE, `busy`=0, `done`=0, `quo`=0, `rem`=0, `fo`=0, `div0`=0, counter 0. Reset mid-operation aborts with no `done` pulse.

## Timing
- Accepting edge k. `busy`=1 from edge k through the edge that enters DONE; `busy`=0 during DONE.
- Normal: RUN steps on edges k+1..k+WIDTH, FIX registers on edge k+WIDTH+1. `done` is high in the cycle after that edge, i.e. WIDTH+2 cycles after `start` was presented (34 for WIDTH=32).
- Div0: FIX on edge k+1, `done` 2 cycles after `start`.
- Back-to-back: `start` in the DONE cycle is accepted; `busy` is high again next cycle with no idle gap.
- `quo`/`rem`/`fo`/`div0` change only on the FIX edge (and reset).

## Structure
- Shared `defs.v`: existing CIDX/VIDX/ZIDX/SIDX flag indices, plus new `DIV_IDLE`, `DIV_RUN`, `DIV_FIX`, `DIV_DONE` 2-bit state encodings.
- One sub-module: the existing `adder` (WIDTH) instantiated for the trial subtraction (ai=partial, bi=~divisor, ci=1; co=1 means no borrow).
- Counter width $clog2(WIDTH).

## Test plan
- Unsigned 100 / 7 → quo=14, rem=2, C=1, Z=0, V=0; `done` exactly 34 cycles after `start`; `busy` low in the `done` cycle.
- Signed −100 / 7 → quo=0xFFFFFFF2, rem=0xFFFFFFFE, S=1, C=1; unsigned 0 / 5 → quo=0, rem=0, Z=1, C=0.
- 5 / 0 → quo=0xFFFFFFFF, rem=5, div0=1, V=1; `done` 2 cycles after `start`; fi bits 8+ pass through unchanged in `fo`.
- Signed 0x80000000 / 0xFFFFFFFF → quo=0x80000000, rem=0, V=1, S=1; unsigned same operands → quo=0, rem=0x80000000, C=1, V=0.
- `start` pulsed mid-RUN with new operands → ignored, original result returned. `start` in the DONE cycle → accepted, second result 34 cycles later.
- `reset_n` low at cycle 10 of RUN → outputs 0 immediately (asynchronously), no `done` pulse. A new `start` after release completes normally.
